// File: rtl/cpu_pkg.sv
// Shared core definitions: fetch FSM states and fetch-unit constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC   = 32'h8000_0000;
    localparam int          INST_BYTES = 4;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one word fetch at a time and
// hands each fetched instruction to execute over a valid/ready handshake.
module ifu_fetch
    import cpu_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = cpu_pkg::RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [DATA_WIDTH-1:0] inst_pc,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  pc_misaligned
);

    fetch_state_t          r_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_inst;
    logic [DATA_WIDTH-1:0] r_inst_pc;
    logic                  r_misaligned;

    logic [DATA_WIDTH-1:0] w_pc_seq;
    logic [DATA_WIDTH-1:0] w_next_pc;
    logic                  w_bad_target;

    // Sequential PC wraps naturally at 2^32; redirect only matters at the handshake.
    assign w_pc_seq     = r_pc + DATA_WIDTH'(INST_BYTES);
    assign w_next_pc    = redirect ? redirect_pc : w_pc_seq;
    assign w_bad_target = redirect && (redirect_pc[1:0] != 2'b00);

    // Fetch FSM: REQ -> WAIT -> HOLD -> REQ, HALT is terminal until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= REQ;
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_misaligned <= 1'b0;
        end else begin
            case (r_state)
                REQ: begin
                    if (imem_req_ready) r_state <= WAIT;
                end
                WAIT: begin
                    // Response is only meaningful here; elsewhere it is ignored.
                    if (imem_resp_valid) begin
                        r_inst    <= imem_resp_data;
                        r_inst_pc <= r_pc;
                        r_state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        if (w_bad_target) begin
                            // PC keeps its old value; the error is sticky.
                            r_misaligned <= 1'b1;
                            r_state      <= HALT;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_state <= REQ;
                        end
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: r_state <= REQ;
            endcase
        end
    end

    // Outputs decode straight from registers, so redirect never reaches inst.
    assign imem_req_valid = (r_state == REQ);
    assign imem_req_addr  = r_pc;
    assign inst_valid     = (r_state == HOLD);
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;
    assign pc_misaligned  = r_misaligned;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a main instance at the default reset PC and a
// second instance at 0xFFFF_FFFC driven in lockstep for the wrap-around case.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_ready = 1'b1;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        inst_ready = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic        req_valid, inst_valid, pc_mis;
    logic [31:0] req_addr, inst, inst_pc;

    logic        w_resp_valid = 1'b0;
    logic [31:0] w_resp_data = '0;
    logic        w_req_valid, w_inst_valid, w_pc_mis;
    logic [31:0] w_req_addr, w_inst, w_inst_pc;

    logic        spurious = 1'b0;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    ifu_fetch u_dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .pc_misaligned(pc_mis)
    );

    ifu_fetch #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(w_req_addr),
        .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
        .inst_valid(w_inst_valid), .inst_ready(inst_ready),
        .inst(w_inst), .inst_pc(w_inst_pc),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .pc_misaligned(w_pc_mis)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // One clock; the memory answers one cycle after accepting a request.
    task automatic tick();
        logic        acc, wacc;
        logic [31:0] a, wa;
        acc  = req_valid && imem_req_ready && !rst;
        wacc = w_req_valid && imem_req_ready && !rst;
        a    = req_addr;
        wa   = w_req_addr;
        @(posedge clk);
        #1;
        imem_resp_valid = acc;
        imem_resp_data  = mem(a);
        w_resp_valid    = wacc;
        w_resp_data     = mem(wa);
        if (spurious) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'hDEAD_BEEF;
            w_resp_valid    = 1'b1;
            w_resp_data     = 32'hDEAD_BEEF;
        end
    endtask

    // Full REQ/WAIT/HOLD round trip; optional stray redirect outside the handshake.
    task automatic fetch_one(input logic [31:0] pc, input logic redir,
                             input logic [31:0] rpc, input logic noise);
        chk("req_valid", {31'b0, req_valid}, 32'd1);
        chk("req_addr", req_addr, pc);
        chk("iv_in_req", {31'b0, inst_valid}, 32'd0);
        if (noise) begin
            redirect    = 1'b1;
            redirect_pc = 32'h8000_0200;
        end
        tick();
        chk("req_v_wait", {31'b0, req_valid}, 32'd0);
        chk("iv_wait", {31'b0, inst_valid}, 32'd0);
        tick();
        chk("iv_hold", {31'b0, inst_valid}, 32'd1);
        chk("inst_pc", inst_pc, pc);
        chk("inst", inst, mem(pc));
        redirect    = redir;
        redirect_pc = rpc;
        tick();
        redirect    = 1'b0;
        redirect_pc = '0;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        // Reset state, first cycle out of reset
        chk("rst_req_v", {31'b0, req_valid}, 32'd1);
        chk("rst_addr", req_addr, 32'h8000_0000);
        chk("rst_iv", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_mis", {31'b0, pc_mis}, 32'd0);
        chk("wrap_rst_addr", w_req_addr, 32'hFFFF_FFFC);

        // Sequential fetch, then wrap instance must land on 0
        fetch_one(32'h8000_0000, 1'b0, '0, 1'b0);
        chk("wrap_inst_pc", w_inst_pc, 32'hFFFF_FFFC);
        chk("wrap_next", w_req_addr, 32'h0000_0000);
        chk("wrap_no_mis", {31'b0, w_pc_mis}, 32'd0);
        // Redirect taken at handshake
        fetch_one(32'h8000_0004, 1'b1, 32'h8000_0100, 1'b0);
        // Redirect outside the handshake is ignored
        fetch_one(32'h8000_0100, 1'b0, '0, 1'b1);

        // Request-side backpressure
        chk("bp_addr0", req_addr, 32'h8000_0104);
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_req_v", {31'b0, req_valid}, 32'd1);
            chk("bp_addr", req_addr, 32'h8000_0104);
        end
        imem_req_ready = 1'b1;
        tick();
        tick();
        chk("bp_hold_pc", inst_pc, 32'h8000_0104);
        // Consumer backpressure with stray responses
        inst_ready = 1'b0;
        spurious   = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("cs_iv", {31'b0, inst_valid}, 32'd1);
            chk("cs_inst", inst, mem(32'h8000_0104));
            chk("cs_pc", inst_pc, 32'h8000_0104);
            chk("cs_no_req", {31'b0, req_valid}, 32'd0);
        end
        spurious   = 1'b0;
        inst_ready = 1'b1;
        tick();

        // Misaligned target halts
        fetch_one(32'h8000_0108, 1'b1, 32'h8000_0102, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("mis_flag", {31'b0, pc_mis}, 32'd1);
            chk("mis_no_req", {31'b0, req_valid}, 32'd0);
            chk("mis_iv", {31'b0, inst_valid}, 32'd0);
            chk("mis_addr", req_addr, 32'h8000_0108);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("post_halt_mis", {31'b0, pc_mis}, 32'd0);
        chk("post_halt_addr", req_addr, 32'h8000_0000);
        chk("post_halt_w", w_req_addr, 32'hFFFF_FFFC);

        // Reset while waiting for a response
        fetch_one(32'h8000_0000, 1'b0, '0, 1'b0);
        tick();
        chk("wait_state", {31'b0, req_valid}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rw_req_v", {31'b0, req_valid}, 32'd1);
        chk("rw_addr", req_addr, 32'h8000_0000);
        chk("rw_iv", {31'b0, inst_valid}, 32'd0);
        chk("rw_inst_pc", inst_pc, 32'd0);
        fetch_one(32'h8000_0000, 1'b0, '0, 1'b0);
        chk("rw_next", req_addr, 32'h8000_0004);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit for the 32-bit RISC-V core, sitting directly upstream of the execute stage. It owns the program counter and issues one word fetch at a time to instruction memory over a valid/ready request and valid response interface. It presents the fetched instruction with its PC to decode/execute over a valid/ready handshake. It consumes the execute stage's `jump`/`upc` outcome to choose the next PC.

## Interface
- `DATA_WIDTH`, 32: address and instruction width.
- `RESET_PC`, 32'h8000_0000: first fetch address after reset.

- `clk` in 1: sole clock. Everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req_valid` out 1: fetch request pending.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_req_addr` out DATA_WIDTH: word-aligned fetch address. Equals the current PC.
- `imem_resp_valid` in 1: response data valid. Exactly one response per accepted request, at least 1 cycle after acceptance.
- `imem_resp_data` in DATA_WIDTH: fetched instruction word.
- `inst_valid` out 1: `inst`/`inst_pc` hold a fetched instruction.
- `inst_ready` in 1: downstream consumes the instruction this cycle.
- `inst` out DATA_WIDTH: instruction word.
- `inst_pc` out DATA_WIDTH: address of `inst`.
- `redirect` in 1: the consumed instruction jumps or takes a branch (execute `jump`).
- `redirect_pc` in DATA_WIDTH: jump/branch target (execute `upc`).
- `pc_misaligned` out 1: sticky error. A redirect target had bits [1:0] != 0.

## Operation
- The FSM has four states:
  - REQ: `imem_req_valid`=1. Go to WAIT when `imem_req_ready`=1.
  - WAIT: no request is driven. On `imem_resp_valid`, latch `imem_resp_data` into `inst` and go to HOLD.
  - HOLD: `inst_valid`=1. On `inst_ready`, update the PC and go to REQ, or to HALT on a misaligned redirect.
  - HALT: all outputs are idle and `pc_misaligned`=1. Only `rst` leaves HALT.
- Next-PC rule, applied only on the `inst_valid && inst_ready` cycle:
  - `redirect`=1: PC = `redirect_pc`.
  - otherwise: PC = PC + 4, modulo 2^32. 0xFFFF_FFFC wraps to 0x0000_0000 with no flag.
- `redirect`/`redirect_pc` are ignored in every other cycle.
- Misaligned redirect (`redirect_pc[1:0]` != 0 at the handshake): the PC is not updated, `pc_misaligned` is set, and the FSM enters HALT. No further requests are issued.
- `imem_resp_valid` outside WAIT is a protocol violation. It is ignored and leaves no state change.
- `inst`/`inst_pc` stay stable for the whole time `inst_valid`=1. `imem_req_addr` stays stable while `imem_req_valid`=1 and not accepted.
- Reset state: FSM = REQ, PC = RESET_PC, `inst_valid`=0, `inst`=0, `inst_pc`=0, `pc_misaligned`=0.
  - `imem_req_valid`=1 with `imem_req_addr`=RESET_PC in the first cycle with `rst`=0.
- Reset mid-operation in any state discards the outstanding request, response and held instruction. Instruction memory shares `rst`, so responses to pre-reset requests never arrive.

## Timing
- Request accepted in cycle N → the response arrives in cycle ≥ N+1.
- The response is latched in cycle R → `inst_valid`=1 in cycle R+1. No combinational path from `imem_resp_data` to `inst`.
- Handshake in cycle M → `imem_req_valid`=1 with the new PC in cycle M+1.
- Best-case throughput is one instruction per 3 cycles: zero-wait memory and an always-ready consumer.
- `inst_ready` held low stretches HOLD indefinitely. There is no timeout.
- `redirect`/`redirect_pc` may depend combinationally on `inst`. This is safe because the unit has no combinational path from `redirect` to `inst`.

## Structure
- Shared package `cpu_pkg`:
  - `fetch_state_t` enum: REQ, WAIT, HOLD, HALT.
  - `RESET_PC` default.
  - `INST_BYTES` = 4.
- No sub-module. The PC register, next-PC mux and FSM live in one module.

## Test plan
- Reset release, memory ready with 1-cycle latency, consumer always ready:
  - requests to 0x8000_0000, 0x8000_0004, 0x8000_0008.
  - `inst_valid` every third cycle.
  - `inst_pc` matches each request address.
- Redirect: on the handshake of the instruction at 0x8000_0004, drive `redirect`=1, `redirect_pc`=0x8000_0100 → the next request address is 0x8000_0100. A later `redirect`=1 with `redirect_pc`=0x8000_0200 in a non-handshake cycle is ignored.
- Backpressure: hold `imem_req_ready`=0 for 5 cycles, then `inst_ready`=0 for 7 cycles:
  - address stays stable throughout the request stall.
  - `inst`/`inst_pc` stay stable throughout the consumer stall.
  - no new request is issued.
- Misaligned target: `redirect_pc`=0x8000_0102 → `pc_misaligned`=1 next cycle, no further `imem_req_valid`, and the state survives until `rst`.
- Wrap-around and reset: with RESET_PC=0xFFFF_FFFC, the sequential fetch after it is 0x0000_0000. Asserting `rst` during WAIT → the next post-reset request goes to RESET_PC with `inst_valid`=0.
